// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the MEM stage and the data-memory port.
// Accepts one request at a time, validates alignment/funct3, runs one
// word-aligned memory access with a timeout, and returns an extended result.
//
// state  | meaning
// IDLE   | ready for a new request
// ACCESS | memory strobe held, waiting for mem_resp or timeout
// RESP   | one-cycle completion pulse, normal response
// ERR    | one-cycle completion pulse, misaligned or illegal funct3
// TOUT   | one-cycle completion pulse, memory timed out
module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_misaligned,
  output logic        rsp_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP,
    S_ERR,
    S_TOUT
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        wr_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [15:0] cnt_q;
  logic        req_illegal;
  logic [31:0] shifted;
  logic [31:0] load_ext;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic        in_access;

  // Request legality: only evaluated in IDLE to pick ACCESS vs ERR.
  always_comb begin
    req_illegal = 1'b0;
    case (req_funct3)
      3'b000:  req_illegal = 1'b0;
      3'b001:  req_illegal = req_addr[0];
      3'b010:  req_illegal = (req_addr[1:0] != 2'b00);
      3'b100:  req_illegal = req_write;
      3'b101:  req_illegal = req_write | req_addr[0];
      default: req_illegal = 1'b1;
    endcase
  end

  // Next-state logic; a response in the timeout cycle still counts as a response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) state_d = req_illegal ? S_ERR : S_ACCESS;
      end
      S_ACCESS: begin
        if (mem_resp)                state_d = S_RESP;
        else if (cnt_q == CNT_LAST)  state_d = S_TOUT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Load extraction from the raw memory word using the latched offset and size.
  always_comb begin
    shifted  = mem_rdata >> {addr_q[1:0], 3'b000};
    load_ext = shifted;
    case (f3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'h0, shifted[7:0]};
      3'b101:  load_ext = {16'h0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // Request fields, access timer and captured load result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      cnt_q   <= 16'h0;
    end else begin
      if (state_q == S_IDLE && req_valid) begin
        wr_q    <= req_write;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == S_ACCESS) cnt_q <= cnt_q + 16'h1;
      else                     cnt_q <= 16'h0;
      if (state_q == S_ACCESS && mem_resp) rdata_q <= load_ext;
    end
  end

  // Store byte lanes and lane-replicated data.
  always_comb begin
    st_mask = 4'b0000;
    st_data = wdata_q;
    case (f3_q)
      3'b000: begin
        st_mask = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        st_mask = 4'b0011 << addr_q[1:0];
        st_data = {2{wdata_q[15:0]}};
      end
      3'b010: begin
        st_mask = 4'b1111;
        st_data = wdata_q;
      end
      default: begin
        st_mask = 4'b0000;
        st_data = wdata_q;
      end
    endcase
  end

  assign in_access      = (state_q == S_ACCESS);
  assign req_ready      = (state_q == S_IDLE);
  assign mem_read       = in_access & ~wr_q;
  assign mem_write      = in_access & wr_q;
  assign mem_addr       = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wmask      = mem_write ? st_mask : 4'b0000;
  assign mem_wdata      = mem_write ? st_data : 32'h0;
  assign rsp_valid      = (state_q == S_RESP) | (state_q == S_ERR) | (state_q == S_TOUT);
  assign rsp_rdata      = (state_q == S_RESP && !wr_q) ? rdata_q : 32'h0;
  assign rsp_misaligned = (state_q == S_ERR);
  assign rsp_timeout    = (state_q == S_TOUT);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: expected responses queued at issue, checked on rsp_valid.
module tb_lsu_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misaligned, rsp_timeout;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        mis;
    logic        to;
  } exp_t;

  exp_t sb_q[$];

  lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_misaligned(rsp_misaligned), .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One full transaction; resp_at = ACCESS cycle index that sees mem_resp (-1: never).
  task automatic run_txn(input string tag, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int resp_at, input logic [31:0] rd, input exp_t e,
                         input int exp_strobes, input int exp_cyc,
                         input logic [31:0] e_addr, input logic [3:0] e_mask,
                         input logic [31:0] e_wdata);
    int   strobes;
    bit   got;
    exp_t p;
    strobes = 0;
    got     = 1'b0;
    @(negedge clk);
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (mem_read || mem_write) begin
        strobes++;
        if (strobes == 1) begin
          check({tag, ".dir"}, 32'({mem_write, mem_read}), wr ? 32'd2 : 32'd1);
          check({tag, ".addr"}, mem_addr, e_addr);
          check({tag, ".mask"}, 32'(mem_wmask), 32'(e_mask));
          if (wr) check({tag, ".wdata"}, mem_wdata, e_wdata);
        end
      end
      if (rsp_valid) begin
        got = 1'b1;
        check({tag, ".cyc"}, 32'(i), 32'(exp_cyc));
        p = sb_q.pop_front();
        check({tag, ".rdata"}, rsp_rdata, p.rdata);
        check({tag, ".mis"}, 32'(rsp_misaligned), 32'(p.mis));
        check({tag, ".to"}, 32'(rsp_timeout), 32'(p.to));
      end
      mem_resp  = (i == resp_at);
      mem_rdata = (i == resp_at) ? rd : 32'hDEAD_BEEF;
      if (!got) @(negedge clk);
    end
    mem_resp = 1'b0;
    if (!got) check({tag, ".norsp"}, 32'd0, 32'd1);
    check({tag, ".strobes"}, 32'(strobes), 32'(exp_strobes));
    @(negedge clk);
    check({tag, ".pulse"}, 32'(rsp_valid), 32'd0);
    check({tag, ".idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; mem_resp = 1'b0; mem_rdata = 32'h0;
    #12;
    check("rst.ready", 32'(req_ready), 32'd1);
    check("rst.valid", 32'(rsp_valid), 32'd0);
    check("rst.strobe", 32'({mem_read, mem_write}), 32'd0);
    check("rst.rdata", rsp_rdata, 32'h0);
    check("rst.flags", 32'({rsp_misaligned, rsp_timeout}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // loads with extraction
    run_txn("lb",  1'b0, 3'b000, 32'h0000_1003, 32'h0, 2, 32'h80FF_1234,
            '{32'hFFFF_FF80, 1'b0, 1'b0}, 3, 3, 32'h0000_1000, 4'h0, 32'h0);
    run_txn("lhu", 1'b0, 3'b101, 32'h0000_1002, 32'h0, 0, 32'h80FF_1234,
            '{32'h0000_80FF, 1'b0, 1'b0}, 1, 1, 32'h0000_1000, 4'h0, 32'h0);
    run_txn("lh",  1'b0, 3'b001, 32'h0000_1002, 32'h0, 1, 32'h80FF_1234,
            '{32'hFFFF_80FF, 1'b0, 1'b0}, 2, 2, 32'h0000_1000, 4'h0, 32'h0);
    run_txn("lbu", 1'b0, 3'b100, 32'h0000_1001, 32'h0, 0, 32'h80FF_1234,
            '{32'h0000_0012, 1'b0, 1'b0}, 1, 1, 32'h0000_1000, 4'h0, 32'h0);
    run_txn("lw",  1'b0, 3'b010, 32'h0000_1004, 32'h0, 0, 32'hCAFE_F00D,
            '{32'hCAFE_F00D, 1'b0, 1'b0}, 1, 1, 32'h0000_1004, 4'h0, 32'h0);

    // stores
    run_txn("sh", 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 2, 32'h0,
            '{32'h0, 1'b0, 1'b0}, 3, 3, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD);
    run_txn("sb", 1'b1, 3'b000, 32'h0000_3001, 32'h7777_7755, 0, 32'h1111_1111,
            '{32'h0, 1'b0, 1'b0}, 1, 1, 32'h0000_3000, 4'b0010, 32'h5555_5555);
    run_txn("sw", 1'b1, 3'b010, 32'h0000_3008, 32'h0BAD_BEEF, 1, 32'h0,
            '{32'h0, 1'b0, 1'b0}, 2, 2, 32'h0000_3008, 4'b1111, 32'h0BAD_BEEF);

    // error path: no strobe, pulse in the first cycle after accept
    run_txn("lw_mis", 1'b0, 3'b010, 32'h0000_1001, 32'h0, -1, 32'h0,
            '{32'h0, 1'b1, 1'b0}, 0, 0, 32'h0, 4'h0, 32'h0);
    run_txn("f3_011", 1'b0, 3'b011, 32'h0000_1000, 32'h0, -1, 32'h0,
            '{32'h0, 1'b1, 1'b0}, 0, 0, 32'h0, 4'h0, 32'h0);
    run_txn("st_f3_100", 1'b1, 3'b100, 32'h0000_1000, 32'h55, -1, 32'h0,
            '{32'h0, 1'b1, 1'b0}, 0, 0, 32'h0, 4'h0, 32'h0);
    run_txn("sh_odd", 1'b1, 3'b001, 32'h0000_1003, 32'h55, -1, 32'h0,
            '{32'h0, 1'b1, 1'b0}, 0, 0, 32'h0, 4'h0, 32'h0);

    // timeout boundary
    run_txn("tout", 1'b0, 3'b010, 32'h0000_0010, 32'h0, -1, 32'h0,
            '{32'h0, 1'b0, 1'b1}, TO, TO, 32'h0000_0010, 4'h0, 32'h0);
    run_txn("tout_edge", 1'b0, 3'b010, 32'h0000_0010, 32'h0, TO - 1, 32'h1234_5678,
            '{32'h1234_5678, 1'b0, 1'b0}, TO, TO, 32'h0000_0010, 4'h0, 32'h0);

    // async reset during ACCESS
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0020;
    @(negedge clk);
    req_valid = 1'b0;
    check("arst.read1", 32'(mem_read), 32'd1);
    @(negedge clk);
    check("arst.read2", 32'(mem_read), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst.drop", 32'(mem_read), 32'd0);
    check("arst.ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mem_resp = 1'b1;
    mem_rdata = 32'hA5A5_A5A5;
    @(negedge clk);
    mem_resp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("arst.norsp", 32'(rsp_valid), 32'd0);
      check("arst.nostrobe", 32'(mem_read | mem_write), 32'd0);
      @(negedge clk);
    end
    check("arst.idle", 32'(req_ready), 32'd1);

    run_txn("post_rst", 1'b0, 3'b000, 32'h0000_0041, 32'h0, 0, 32'h0000_7F00,
            '{32'h0000_007F, 1'b0, 1'b0}, 1, 1, 32'h0000_0040, 4'h0, 32'h0);

    check("sb.empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
